tx_3b2t_enc: RTL

- Transmit PCS stage directly downstream of the 4B3B converter, in the 33 MHz domain.
- Consumes 3-bit groups (tx_data/tx_data_en) and side-stream scrambles them.
- Replaces the packet head with a start delimiter (SSD) and appends an end delimiter (ESD).
- Maps each 3-bit group to one ternary pair (TA,TB) for the PMA transmitter.

---
 rtl/tx_3b2t_enc.sv | 89 ++++++++
 1 files changed

// File: rtl/tx_3b2t_enc.sv
// tx_3b2t_enc: side-stream scrambled 3B2T transmit encoder with SSD/ESD framing
module tx_3b2t_enc #(
  parameter logic [32:0] SCR_SEED = 33'h0_0000_0001,
  parameter bit          IDLE_SCR = 1'b1
) (
  input  logic       sys_clk_33m,
  input  logic       rst_n_33m,
  input  logic [2:0] tx_data,
  input  logic       tx_data_en,
  input  logic       scr_bypass,
  output logic [1:0] tx_ta,
  output logic [1:0] tx_tb,
  output logic       tx_sym_valid,
  output logic       tx_active
);
  localparam logic [1:0] S_IDLE = 2'd0, S_SSD = 2'd1, S_DATA = 2'd2, S_ESD = 2'd3;
  localparam logic [1:0] P = 2'b01, N = 2'b11, Z = 2'b00;
  localparam logic [32:0] SEED = (SCR_SEED == 33'd0) ? 33'd1 : SCR_SEED;
  logic [32:0] s, s1, s2, s3;
  logic [2:0]  c, d_r;
  logic        en_r;
  logic [1:0]  st, cnt, nst, ncnt;
  logic [3:0]  pair;
  function automatic logic [3:0] map3(input logic [2:0] v);
    case (v)
      3'b000:  map3 = {N, N};
      3'b001:  map3 = {N, Z};
      3'b010:  map3 = {N, P};
      3'b011:  map3 = {Z, N};
      3'b100:  map3 = {Z, P};
      3'b101:  map3 = {P, N};
      3'b110:  map3 = {P, Z};
      default: map3 = {P, P};
    endcase
  endfunction
  assign s1 = {s[31:0], s[32] ^ s[19]};
  assign s2 = {s1[31:0], s1[32] ^ s1[19]};
  assign s3 = {s2[31:0], s2[32] ^ s2[19]};
  assign c  = scr_bypass ? 3'b000 : {s3[0], s2[0], s1[0]};
  // Next state names what the output register shows next; the registered group that
  // triggers a new packet is itself consumed as SSD slot 0.
  always_comb begin
    nst  = S_IDLE;
    ncnt = 2'd0;
    case (st)
      S_IDLE: nst = tx_en_sel(en_r, S_SSD, S_IDLE);
      S_SSD: begin
        nst  = cnt != 2'd2 ? S_SSD : tx_en_sel(en_r, S_DATA, S_ESD);
        ncnt = cnt != 2'd2 ? cnt + 2'd1 : 2'd0;
      end
      S_DATA: nst = tx_en_sel(en_r, S_DATA, S_ESD);
      S_ESD: begin
        nst  = cnt != 2'd2 ? S_ESD : tx_en_sel(en_r, S_SSD, S_IDLE);
        ncnt = cnt != 2'd2 ? cnt + 2'd1 : 2'd0;
      end
      default: nst = S_IDLE;
    endcase
  end
  function automatic logic [1:0] tx_en_sel(input logic e, input logic [1:0] a, input logic [1:0] b);
    tx_en_sel = e ? a : b;
  endfunction
  assign pair = nst == S_DATA ? map3(d_r ^ c) :
                nst == S_IDLE ? (IDLE_SCR ? map3(c) : 4'b0000) :
                (nst == S_ESD && ncnt == 2'd2) ? {P, P} : 4'b0000;
  // Input capture, scrambler advance and registered symbol output
  always_ff @(posedge sys_clk_33m or negedge rst_n_33m) begin
    if (!rst_n_33m) begin
      s            <= SEED;
      en_r         <= 1'b0;
      d_r          <= 3'b000;
      st           <= S_IDLE;
      cnt          <= 2'd0;
      tx_ta        <= 2'b00;
      tx_tb        <= 2'b00;
      tx_sym_valid <= 1'b0;
      tx_active    <= 1'b0;
    end else begin
      s            <= s3;
      en_r         <= tx_data_en;
      d_r          <= tx_data;
      st           <= nst;
      cnt          <= ncnt;
      tx_ta        <= pair[3:2];
      tx_tb        <= pair[1:0];
      tx_sym_valid <= 1'b1;
      tx_active    <= nst != S_IDLE;
    end
  end
endmodule
